spi_tx_queue: RTL and testbench
===============================

// Module: spi_tx_queue
// PURPOSE
//   Transmit-side feeder for SpiOut. Buffers 16-bit words from the CPU/bus
//   in a small FIFO and launches them one frame at a time into SpiOut.
//   Pacing: drives SpiOut's data bus, pulses writeSPI, and tracks
//   masterChipSelectN so a new frame never starts while one is on MOSI.
//   Sits between the bus write port and SpiOut.
// PARAMETERS
//   WIDTH       16  word width; must equal the SpiOut data width
//   DEPTH       4   FIFO entries; power of 2, >= 2
//   ADDR_W      2   log2(DEPTH)
//   GAP_CYCLES  2   idle clocks forced after CSN deasserts, before the next launch (>= 1)
// PORTS
//   clock              in   1           system clock, rising edge
//   resetN             in   1           asynchronous reset, active low
//   wrData             in   WIDTH       word to enqueue
//   wrStrobe           in   1           enqueue wrData this cycle
//   full               out  1           count == DEPTH
//   empty              out  1           count == 0
//   count              out  ADDR_W+1    words held (0..DEPTH)
//   overflow           out  1           sticky: a push was dropped; cleared only by reset
//   spiData            out  WIDTH       to SpiOut.data; stable from launch to end of frame
//   writeSPI           out  1           to SpiOut.writeSPI; one-clock launch pulse
//   masterChipSelectN  in   1           from SpiOut; low while a frame shifts
//   busy               out  1           state != IDLE
//   timeoutErr         out  1           sticky launch-timeout flag (see CONFIGURATION)
// BEHAVIOUR
//   Reset (resetN low, async): FIFO emptied; state IDLE; spiData=0; writeSPI=0;
//     overflow=0; timeoutErr=0; count=0; empty=1; full=0.
//   FIFO: circular buffer; rd/wr pointers ADDR_W bits wide, wrap modulo DEPTH; count is separate.
//     - Push when wrStrobe && (!full || pop this cycle); else drop, set overflow.
//     - Pop happens only on the IDLE->LAUNCH transition.
//     - Simultaneous push+pop: count unchanged, both pointers advance.
//   FSM (registered, one transition per clock):
//     IDLE     : if !empty && masterChipSelectN: spiData<=head, pop, ->LAUNCH
//     LAUNCH   : writeSPI=1 for exactly this cycle; ->WAIT_LO
//     WAIT_LO  : CSN low -> WAIT_HI; else stay
//     WAIT_HI  : CSN high -> GAP (gap counter <= GAP_CYCLES-1)
//     GAP      : count down; at 0 -> IDLE
//   Latency:
//     - Push into an empty idle queue to writeSPI high = 2 clocks
//       (push edge, IDLE pop edge, LAUNCH).
//     - writeSPI is a Moore output of LAUNCH; never high two consecutive clocks.
//   spiData changes only on the IDLE->LAUNCH edge. The word handed to SpiOut
//     is held for the whole frame.
//   Boundaries:
//     - CSN already low in IDLE (foreign frame): no launch until CSN high.
//     - Push to a full queue while a frame is in flight: dropped, overflow=1.
//     - DEPTH pushes with no pop: full=1, count=DEPTH; pointers wrap to 0.
//     - resetN low mid-frame: immediate return to reset values. Pending words
//       are lost; SpiOut finishes or aborts its frame independently.
// CONFIGURATION
//   SPI_TX_TIMEOUT_EN defined:
//     - WAIT_LO carries a 6-bit counter cleared in LAUNCH.
//     - CSN still high after 32 clocks in WAIT_LO: timeoutErr<=1, ->GAP. The word is discarded.
//   SPI_TX_TIMEOUT_EN undefined:
//     - WAIT_LO waits indefinitely.
//     - timeoutErr is tied 0; no counter logic is synthesised.
// TESTING (bench pairs this block with SpiOut and SpiIn; clock period 20)
//   1 Reset, push 16'h5055 -> writeSPI pulses once 2 clocks later; SpiIn
//     interupt rises with dataIn=16'h5055; busy returns 0 after GAP_CYCLES.
//   2 Push 16'hD655, 16'h1255, 16'hABCD back-to-back -> three frames in
//     order; exactly one writeSPI per frame; >= GAP_CYCLES clocks of CSN high between frames.
//   3 Push 5 words with DEPTH=4 while the first frame is in flight -> 1 in
//     flight + 4 queued accepted; 6th push dropped, overflow=1, full=1.
//   4 Push and launch-pop in the same clock with count=4 -> count stays 4;
//     no overflow; wrap-around order preserved on readout.
//   5 Assert resetN low mid-frame with 2 words queued -> count=0, empty=1, writeSPI=0
//     immediately; after release no further writeSPI pulses.
//   6 (SPI_TX_TIMEOUT_EN) hold CSN high externally (SpiOut stubbed), push
//     16'h0001 -> timeoutErr=1 after 32 WAIT_LO clocks; FSM back to IDLE.

Source files
------------

// File: rtl/spi_tx_queue.sv
// spi_tx_queue: transmit-side feeder for SpiOut.
//   Buffers WIDTH-bit words in a DEPTH-entry circular FIFO. Launches them one
//   frame at a time: it drives spiData, pulses writeSPI for one clock, then
//   follows masterChipSelectN through the frame. A forced idle gap follows
//   before the next launch.
// Ports:
//   clock, resetN        rising-edge clock, async active-low reset
//   wrData, wrStrobe     enqueue port
//   full, empty, count   FIFO occupancy (count = 0..DEPTH)
//   overflow             sticky dropped-push flag, cleared only by reset
//   spiData, writeSPI    to SpiOut; spiData is held from launch to frame end
//   masterChipSelectN    from SpiOut, low while a frame shifts
//   busy                 FSM not idle
//   timeoutErr           sticky launch-timeout flag
// Build option: define SPI_TX_TIMEOUT_EN to abandon a launch if CSN has not
//   gone low within 32 clocks. Otherwise timeoutErr is tied low.
module spi_tx_queue #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic [WIDTH-1:0]  wrData,
  input  logic              wrStrobe,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [WIDTH-1:0]  spiData,
  output logic              writeSPI,
  input  logic              masterChipSelectN,
  output logic              busy,
  output logic              timeoutErr
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
  localparam logic [GW-1:0]     GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0]     GAP_ONE  = 1;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_LO, WAIT_HI, GAP} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [ADDR_W:0]   cnt;
  logic [GW-1:0]     gap_cnt;
  logic              pop, push, gap_load;

  assign full     = (cnt == CNT_FULL);
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign writeSPI = (state == LAUNCH);
  assign busy     = (state != IDLE);

  // A pop frees a slot in the same clock, so a push into a full queue is
  // still accepted when it coincides with a launch.
  assign pop  = (state == IDLE) && !empty && masterChipSelectN;
  assign push = wrStrobe && (!full || pop);

`ifdef SPI_TX_TIMEOUT_EN
  logic [5:0] tmo_cnt;
  logic       tmo_fire;
`endif

  always_comb begin
    state_nxt = state;
    gap_load  = 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
    tmo_fire  = 1'b0;
`endif
    case (state)
      IDLE:    if (pop) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT_LO;
      WAIT_LO: begin
        if (!masterChipSelectN) state_nxt = WAIT_HI;
`ifdef SPI_TX_TIMEOUT_EN
        // 32nd WAIT_LO clock with CSN still high: give up on this word.
        else if (tmo_cnt == 6'd31) begin
          state_nxt = GAP;
          gap_load  = 1'b1;
          tmo_fire  = 1'b1;
        end
`endif
      end
      WAIT_HI: if (masterChipSelectN) begin
        state_nxt = GAP;
        gap_load  = 1'b1;
      end
      GAP:     if (gap_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)                         gap_cnt <= '0;
    else if (gap_load)                   gap_cnt <= GAP_LOAD;
    else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GAP_ONE;
  end

  // Storage needs no reset: count==0 marks every entry invalid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wrData;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
      spiData  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        spiData <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
      if (wrStrobe && !push) overflow <= 1'b1;
    end
  end

`ifdef SPI_TX_TIMEOUT_EN
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      tmo_cnt    <= '0;
      timeoutErr <= 1'b0;
    end else begin
      if (state == LAUNCH)       tmo_cnt <= '0;
      else if (state == WAIT_LO) tmo_cnt <= tmo_cnt + 6'd1;
      if (tmo_fire) timeoutErr <= 1'b1;
    end
  end
`else
  assign timeoutErr = 1'b0;
`endif

endmodule

// File: tb/tb_spi_tx_queue.sv
module tb_spi_tx_queue;
  localparam int WIDTH = 16, DEPTH = 4, ADDR_W = 2, GAP = 2;

  logic clock = 1'b0, resetN = 1'b0, wrStrobe = 1'b0;
  logic [WIDTH-1:0] wrData = '0;
  logic spi_csn = 1'b1, foreign_low = 1'b0, spi_en = 1'b1;
  logic masterChipSelectN;
  logic full, empty, overflow, writeSPI, busy, timeoutErr;
  logic [ADDR_W:0] count;
  logic [WIDTH-1:0] spiData;

  assign masterChipSelectN = spi_csn && !foreign_low;

  spi_tx_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP)) dut (
    .clock(clock), .resetN(resetN), .wrData(wrData), .wrStrobe(wrStrobe),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .spiData(spiData), .writeSPI(writeSPI), .masterChipSelectN(masterChipSelectN),
    .busy(busy), .timeoutErr(timeoutErr));

  always #10 clock = ~clock;

  int n_vec = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue of accepted words plus timestamps of the frame in flight. The unit
  // is busy from the launch edge until GAP clocks after the edge on which CSN
  // is first seen high again after having been seen low (at least two edges
  // after launch), or after a 32-clock launch timeout when enabled.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] exp_launch[$];
  bit m_act, m_ovf, m_tmo, m_pop;
  int m_n = 0, m_tl, m_tlo, m_tend, wspi_pulses = 0;
  logic [WIDTH-1:0] m_data;

  task automatic m_reset();
    mq.delete(); exp_launch.delete();
    m_act = 0; m_ovf = 0; m_tmo = 0; m_pop = 0; m_data = '0;
    m_tl = 0; m_tlo = -1; m_tend = -1;
  endtask

  always @(posedge clock or negedge resetN) begin : model
    bit idle_pre, csn;
    if (!resetN) m_reset();
    else begin
      m_n++;
      csn = masterChipSelectN;
      idle_pre = !m_act;
      if (m_act && m_tend < 0) begin
        if (m_tlo < 0) begin
          if (m_n >= m_tl + 2 && !csn) m_tlo = m_n;
`ifdef SPI_TX_TIMEOUT_EN
          else if (m_n == m_tl + 33) begin m_tmo = 1; m_tend = m_n + GAP; end
`endif
        end else if (m_n > m_tlo && csn) m_tend = m_n + GAP;
      end else if (m_act && m_n == m_tend) m_act = 0;
      m_pop = idle_pre && mq.size() > 0 && csn;
      if (m_pop) begin
        m_data = mq.pop_front();
        exp_launch.push_back(m_data);
        m_act = 1; m_tl = m_n; m_tlo = -1; m_tend = -1;
      end
      if (wrStrobe) begin
        if (mq.size() < DEPTH) mq.push_back(wrData);
        else m_ovf = 1;
      end
      #1;
      chk("m_writeSPI", writeSPI, m_pop);
      chk("m_spiData", spiData, m_data);
      chk("m_count", count, mq.size());
      chk("m_full", full, mq.size() == DEPTH);
      chk("m_empty", empty, mq.size() == 0);
      chk("m_overflow", overflow, m_ovf);
      chk("m_busy", busy, m_act);
      chk("m_timeoutErr", timeoutErr, m_tmo);
      if (writeSPI) wspi_pulses++;
    end
  end

  // ---------------- SpiOut stand-in ----------------
  bit sp_pend = 0;
  int sp_dly = 0, sp_lo = 0, frames = 0, cyc = 0, last_end = -100;
  logic [WIDTH-1:0] sp_cap;
  always @(negedge clock or negedge resetN) begin
    cyc++;
    if (!resetN) begin
      sp_pend = 0; sp_lo = 0; spi_csn = 1'b1; last_end = -100;
    end else if (spi_en) begin
      if (writeSPI) begin
        sp_cap = spiData; sp_pend = 1; sp_dly = $urandom_range(0, 2);
        if (exp_launch.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL frame_order: unexpected launch of %0h", spiData);
        end else chk("frame_data", spiData, exp_launch.pop_front());
      end else if (sp_pend) begin
        if (sp_dly == 0) begin
          chk("csn_gap", (cyc - last_end) > GAP, 1);
          spi_csn = 1'b0; sp_lo = $urandom_range(2, 6); sp_pend = 0; frames++;
        end else sp_dly--;
      end else if (sp_lo > 0) begin
        sp_lo--;
        if (sp_lo == 0) begin
          chk("frame_hold", spiData, sp_cap);
          spi_csn = 1'b1; last_end = cyc;
        end
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic tick(); @(negedge clock); endtask
  task automatic push(input logic [WIDTH-1:0] d);
    wrData = d; wrStrobe = 1'b1; tick(); wrStrobe = 1'b0;
  endtask
  task automatic do_reset();
    wrStrobe = 1'b0; foreign_low = 1'b0; resetN = 1'b0; tick(); resetN = 1'b1; tick();
  endtask
  task automatic wait_idle(input string nm, input int lim);
    int i;
    for (i = 0; i < lim; i++) begin tick(); if (!busy && empty) break; end
    chk(nm, i < lim, 1);
  endtask
  task automatic wait_wspi(input string nm, input int lim);
    int i;
    for (i = 0; i < lim; i++) begin if (writeSPI) break; tick(); end
    chk(nm, i < lim, 1);
  endtask

  typedef struct {
    logic wr; logic [WIDTH-1:0] d; logic fl;
    logic [ADDR_W:0] e_cnt; logic e_full, e_empty, e_ovf, e_wspi;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int f0, p0;
    tbl[0] = '{1'b1, 16'hA001, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 16'hA002, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 16'hA003, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 16'hA004, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 16'hA005, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 16'h0000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset values
    repeat (3) tick();
    #1;
    chk("rst_count", count, 0); chk("rst_empty", empty, 1); chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0); chk("rst_wspi", writeSPI, 0); chk("rst_data", spiData, 0);
    chk("rst_busy", busy, 0); chk("rst_tmo", timeoutErr, 0);
    tick(); resetN = 1'b1; tick();

    // 1: single word, two-clock launch latency
    f0 = frames;
    wrData = 16'h5055; wrStrobe = 1'b1;
    @(posedge clock); #1 chk("t1_wspi_e0", writeSPI, 0); chk("t1_cnt_e0", count, 1);
    @(negedge clock) wrStrobe = 1'b0;
    @(posedge clock); #1 chk("t1_wspi_e1", writeSPI, 1); chk("t1_data", spiData, 16'h5055);
    @(posedge clock); #1 chk("t1_wspi_e2", writeSPI, 0);
    tick();
    wait_idle("t1_idle", 60);
    chk("t1_frames", frames - f0, 1);

    // 2: three back-to-back words
    f0 = frames;
    push(16'hD655); push(16'h1255); push(16'hABCD);
    wait_idle("t2_idle", 150);
    chk("t2_frames", frames - f0, 3);

    // 4: fill to DEPTH behind a foreign frame, then push on the launch clock
    f0 = frames;
    foreign_low = 1'b1;
    push(16'hB001); push(16'hB002); push(16'hB003); push(16'hB004);
    foreign_low = 1'b0; wrData = 16'hB005; wrStrobe = 1'b1;
    @(posedge clock); #1 chk("t4_count", count, 4); chk("t4_wspi", writeSPI, 1);
    chk("t4_ovf", overflow, 0); chk("t4_data", spiData, 16'hB001);
    @(negedge clock) wrStrobe = 1'b0;
    wait_idle("t4_idle", 200);
    chk("t4_frames", frames - f0, 5);

    // Table: foreign frame holds off launch; DEPTH pushes; overflow
    for (int i = 0; i < 8; i++) begin
      wrStrobe = tbl[i].wr; wrData = tbl[i].d; foreign_low = tbl[i].fl;
      @(posedge clock); #1;
      chk($sformatf("tbl%0d_cnt", i), count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_full", i), full, tbl[i].e_full);
      chk($sformatf("tbl%0d_empty", i), empty, tbl[i].e_empty);
      chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].e_ovf);
      chk($sformatf("tbl%0d_wspi", i), writeSPI, tbl[i].e_wspi);
      tick();
    end
    wrStrobe = 1'b0;
    wait_idle("tbl_idle", 200);

    // 3: five pushes while the first frame is in flight
    do_reset();
    f0 = frames;
    push(16'hC000);
    wait_wspi("t3_launch", 10);
    push(16'hC001); push(16'hC002); push(16'hC003); push(16'hC004); push(16'hC005);
    #1 chk("t3_ovf", overflow, 1); chk("t3_full", full, 1); chk("t3_count", count, 4);
    tick();
    wait_idle("t3_idle", 200);
    chk("t3_frames", frames - f0, 5);

    // 5: reset mid-frame with two words queued
    do_reset();
    push(16'hE001); push(16'hE002); push(16'hE003);
    #1 chk("t5_pre_cnt", count, 2); chk("t5_pre_busy", busy, 1);
    resetN = 1'b0;
    #1 chk("t5_cnt", count, 0); chk("t5_empty", empty, 1); chk("t5_wspi", writeSPI, 0);
    chk("t5_busy", busy, 0);
    tick(); resetN = 1'b1;
    p0 = wspi_pulses;
    repeat (30) tick();
    chk("t5_no_pulse", wspi_pulses - p0, 0);

`ifdef SPI_TX_TIMEOUT_EN
    // 6: CSN never falls; launch times out
    spi_en = 1'b0;
    push(16'h0001);
    for (int i = 0; i < 60 && !timeoutErr; i++) tick();
    chk("t6_tmo", timeoutErr, 1);
    wait_idle("t6_idle", 20);
    spi_en = 1'b1;
    do_reset();
`endif

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      wrStrobe = ($urandom_range(0, 99) < 30);
      wrData = WIDTH'($urandom);
      foreign_low = !busy && ($urandom_range(0, 9) == 0);
      tick();
    end
    wrStrobe = 1'b0; foreign_low = 1'b0;
    wait_idle("rand_drain", 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
